// File: rtl/id_ex_pkg.sv
// Shared RV32I bus widths and constants for the decode/execute pipeline register.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package id_ex_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;
  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;
  localparam int MemAddrBus  = 32;

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg      = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

  // addi x0,x0,0 -- the canonical RV32I no-op used to fill a bubble
  localparam logic [InstBus-1:0]    INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/id_ex_if.sv
// Bundle of decode-side inputs, ctrl/ex redirects and execute-side outputs of id_ex.
// Latency: n/a (wiring only).
// Backpressure: hold_i stalls the stage; there is no ready signal back to decode.
interface id_ex_if #(
  parameter int CNT_W = 16
);
  import id_ex_pkg::*;

  // control
  logic                   hold_i;
  logic                   flush_i;
  logic                   ex_jump_flag_i;

  // decode side
  logic [InstBus-1:0]     inst_i;
  logic [InstAddrBus-1:0] inst_addr_i;
  logic [RegBus-1:0]      op1_i;
  logic [RegBus-1:0]      op2_i;
  logic [RegBus-1:0]      op1_jump_i;
  logic [RegBus-1:0]      op2_jump_i;
  logic [RegBus-1:0]      reg1_rdata_i;
  logic [RegBus-1:0]      reg2_rdata_i;
  logic                   reg_we_i;
  logic [RegAddrBus-1:0]  reg_waddr_i;
  logic                   csr_we_i;
  logic [RegBus-1:0]      csr_rdata_i;
  logic [MemAddrBus-1:0]  csr_waddr_i;

  // execute side
  logic [InstBus-1:0]     inst_o;
  logic [InstAddrBus-1:0] inst_addr_o;
  logic [RegBus-1:0]      op1_o;
  logic [RegBus-1:0]      op2_o;
  logic [RegBus-1:0]      op1_jump_o;
  logic [RegBus-1:0]      op2_jump_o;
  logic [RegBus-1:0]      reg1_rdata_o;
  logic [RegBus-1:0]      reg2_rdata_o;
  logic                   reg_we_o;
  logic [RegAddrBus-1:0]  reg_waddr_o;
  logic                   csr_we_o;
  logic [RegBus-1:0]      csr_rdata_o;
  logic [MemAddrBus-1:0]  csr_waddr_o;
  logic                   valid_o;
  logic [CNT_W-1:0]       bubble_cnt_o;

  // pipeline register side
  modport slave (
    input  hold_i, flush_i, ex_jump_flag_i,
    input  inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
    input  reg1_rdata_i, reg2_rdata_i, reg_we_i, reg_waddr_i,
    input  csr_we_i, csr_rdata_i, csr_waddr_i,
    output inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o,
    output reg1_rdata_o, reg2_rdata_o, reg_we_o, reg_waddr_o,
    output csr_we_o, csr_rdata_o, csr_waddr_o, valid_o, bubble_cnt_o
  );

  // decode/ctrl/ex side driving the stage
  modport master (
    output hold_i, flush_i, ex_jump_flag_i,
    output inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
    output reg1_rdata_i, reg2_rdata_i, reg_we_i, reg_waddr_i,
    output csr_we_i, csr_rdata_i, csr_waddr_i,
    input  inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o,
    input  reg1_rdata_o, reg2_rdata_o, reg_we_o, reg_waddr_o,
    input  csr_we_o, csr_rdata_o, csr_waddr_o, valid_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_pipe_dff.sv
// One pipeline field register with priority reset > flush > hold > load.
// Latency: 1 cycle from d to q.
// Backpressure: hold keeps the stored value; flush overrides hold.
module pipe_dff #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  // next value: a flush removes the wrong-path entry even while stalled
  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = RST_VAL;
    end else if (!hold) begin
      data_d = d;
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register with stall, flush/bubble, valid bit and bubble counter.
// Latency: 1 cycle, no combinational input-to-output path.
// Backpressure: hold_i freezes the stage; flush_i/ex_jump_flag_i load a NOP bubble and win over hold.
module id_ex
  import id_ex_pkg::*;
#(
  parameter logic [InstBus-1:0] NOP_INST = INST_NOP,
  parameter int                 CNT_W    = 16
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  logic             flush;
  logic             reg_we_q;
  logic             csr_we_q;
  logic             valid_d;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // a trap flush from ctrl and a taken branch from ex both squash the stage
  assign flush = bus.flush_i | bus.ex_jump_flag_i;

  pipe_dff #(.DW(InstBus), .RST_VAL(NOP_INST)) u_inst (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.inst_i), .q(bus.inst_o));
  pipe_dff #(.DW(InstAddrBus), .RST_VAL(ZeroWord)) u_inst_addr (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.inst_addr_i), .q(bus.inst_addr_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_op1 (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.op1_i), .q(bus.op1_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_op2 (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.op2_i), .q(bus.op2_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_op1_jump (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.op1_jump_i), .q(bus.op1_jump_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_op2_jump (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.op2_jump_i), .q(bus.op2_jump_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_reg1_rdata (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.reg1_rdata_i), .q(bus.reg1_rdata_o));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_reg2_rdata (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.reg2_rdata_i), .q(bus.reg2_rdata_o));
  pipe_dff #(.DW(1), .RST_VAL(WriteDisable)) u_reg_we (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.reg_we_i), .q(reg_we_q));
  pipe_dff #(.DW(RegAddrBus), .RST_VAL(ZeroReg)) u_reg_waddr (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.reg_waddr_i), .q(bus.reg_waddr_o));
  pipe_dff #(.DW(1), .RST_VAL(WriteDisable)) u_csr_we (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.csr_we_i), .q(csr_we_q));
  pipe_dff #(.DW(RegBus), .RST_VAL(ZeroWord)) u_csr_rdata (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.csr_rdata_i), .q(bus.csr_rdata_o));
  pipe_dff #(.DW(MemAddrBus), .RST_VAL(ZeroWord)) u_csr_waddr (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .flush(flush), .d(bus.csr_waddr_i), .q(bus.csr_waddr_o));

  // valid tracks whether the stage holds a real instruction; counter saturates instead of wrapping
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!bus.hold_i) begin
      valid_d = WriteEnable;
    end
  end

  // valid bit and bubble counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // a bubble must never write back, whatever the enable registers hold
  assign bus.reg_we_o     = valid_q ? reg_we_q : WriteDisable;
  assign bus.csr_we_o     = valid_q ? csr_we_q : WriteDisable;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex.sv
// Randomised and directed bench for id_ex, checked against a behavioural stage model.
// Latency: checks outputs one edge after inputs are applied.
// Backpressure: exercises hold, flush, jump and reset in every combination.
module tb_id_ex;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op1j;
    logic [31:0] op2j;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  waddr;
    logic        cwe;
    logic [31:0] crd;
    logic [31:0] cwa;
  } st_t;

  logic clk = 1'b0;
  logic rst;
  logic hold, flush, jump;
  st_t  in_s;

  // model state
  st_t  exp_s;
  logic exp_valid;
  int   exp_c16, exp_c4;
  bit   model_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_if #(.CNT_W(16)) bus16 ();
  id_ex_if #(.CNT_W(4))  bus4 ();

  id_ex #(.NOP_INST(32'h0000_0013), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  id_ex #(.NOP_INST(32'h0000_0013), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // both builds see the same stimulus
  assign bus16.hold_i = hold;          assign bus4.hold_i = hold;
  assign bus16.flush_i = flush;        assign bus4.flush_i = flush;
  assign bus16.ex_jump_flag_i = jump;  assign bus4.ex_jump_flag_i = jump;
  assign bus16.inst_i = in_s.inst;     assign bus4.inst_i = in_s.inst;
  assign bus16.inst_addr_i = in_s.addr; assign bus4.inst_addr_i = in_s.addr;
  assign bus16.op1_i = in_s.op1;       assign bus4.op1_i = in_s.op1;
  assign bus16.op2_i = in_s.op2;       assign bus4.op2_i = in_s.op2;
  assign bus16.op1_jump_i = in_s.op1j; assign bus4.op1_jump_i = in_s.op1j;
  assign bus16.op2_jump_i = in_s.op2j; assign bus4.op2_jump_i = in_s.op2j;
  assign bus16.reg1_rdata_i = in_s.r1; assign bus4.reg1_rdata_i = in_s.r1;
  assign bus16.reg2_rdata_i = in_s.r2; assign bus4.reg2_rdata_i = in_s.r2;
  assign bus16.reg_we_i = in_s.we;     assign bus4.reg_we_i = in_s.we;
  assign bus16.reg_waddr_i = in_s.waddr; assign bus4.reg_waddr_i = in_s.waddr;
  assign bus16.csr_we_i = in_s.cwe;    assign bus4.csr_we_i = in_s.cwe;
  assign bus16.csr_rdata_i = in_s.crd; assign bus4.csr_rdata_i = in_s.crd;
  assign bus16.csr_waddr_i = in_s.cwa; assign bus4.csr_waddr_i = in_s.cwa;

  st_t out16, out4;
  assign out16 = {bus16.inst_o, bus16.inst_addr_o, bus16.op1_o, bus16.op2_o, bus16.op1_jump_o,
                  bus16.op2_jump_o, bus16.reg1_rdata_o, bus16.reg2_rdata_o, bus16.reg_we_o,
                  bus16.reg_waddr_o, bus16.csr_we_o, bus16.csr_rdata_o, bus16.csr_waddr_o};
  assign out4  = {bus4.inst_o, bus4.inst_addr_o, bus4.op1_o, bus4.op2_o, bus4.op1_jump_o,
                  bus4.op2_jump_o, bus4.reg1_rdata_o, bus4.reg2_rdata_o, bus4.reg_we_o,
                  bus4.reg_waddr_o, bus4.csr_we_o, bus4.csr_rdata_o, bus4.csr_waddr_o};

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic st_t nop_st();
    st_t s;
    s = '0;
    s.inst = 32'h0000_0013;
    return s;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    s.inst  = $urandom; s.addr = $urandom; s.op1 = $urandom; s.op2 = $urandom;
    s.op1j  = $urandom; s.op2j = $urandom; s.r1 = $urandom; s.r2 = $urandom;
    s.we    = 1'($urandom_range(0, 1)); s.waddr = 5'($urandom_range(0, 31));
    s.cwe   = 1'($urandom_range(0, 1)); s.crd = $urandom; s.cwa = $urandom;
    return s;
  endfunction

  // behavioural model: what the stage must contain after each edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      exp_s = nop_st(); exp_valid = 1'b0; exp_c16 = 0; exp_c4 = 0;
    end else if (flush || jump) begin
      exp_s = nop_st(); exp_valid = 1'b0;
      if (exp_c16 < 65535) exp_c16++;
      if (exp_c4 < 15) exp_c4++;
    end else if (!hold) begin
      exp_s = in_s; exp_valid = 1'b1;
    end
    model_ok = 1'b1;
  end

  // compare every cycle, mid-period, after the inputs have already moved on
  always @(negedge clk) begin
    st_t e;
    #2;
    if (model_ok) begin
      e = exp_s;
      if (!exp_valid) begin
        e.we = 1'b0;
        e.cwe = 1'b0;
      end
      chk("stage16", out16, e);
      chk("stage4", out4, e);
      chk("valid16", bus16.valid_o, exp_valid);
      chk("valid4", bus4.valid_o, exp_valid);
      chk("cnt16", bus16.bubble_cnt_o, exp_c16);
      chk("cnt4", bus4.bubble_cnt_o, exp_c4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [31:0] nxt;
    rst = 1'b0; hold = 1'b0; flush = 1'b0; jump = 1'b0;
    in_s = rand_st();

    // reset with random inputs for two edges
    tick();
    in_s = rand_st(); hold = 1'($urandom_range(0, 1));
    tick();
    chk("rst_inst", bus16.inst_o, 32'h0000_0013);
    chk("rst_op1", bus16.op1_o, 32'h0);
    chk("rst_csr_waddr", bus16.csr_waddr_o, 32'h0);
    chk("rst_we", {bus16.reg_we_o, bus16.csr_we_o}, 2'b00);
    chk("rst_valid", bus16.valid_o, 1'b0);
    chk("rst_cnt", bus16.bubble_cnt_o, 16'h0);

    // pass-through: nothing visible before the edge
    rst = 1'b1; hold = 1'b0;
    in_s = rand_st();
    in_s.inst = 32'h0050_0093; in_s.op2 = 32'd5; in_s.we = 1'b1; in_s.waddr = 5'd1;
    #1;
    chk("pre_edge_inst", bus16.inst_o, 32'h0000_0013);
    chk("pre_edge_valid", bus16.valid_o, 1'b0);
    tick();
    chk("pt_inst", bus16.inst_o, 32'h0050_0093);
    chk("pt_op2", bus16.op2_o, 32'd5);
    chk("pt_we_waddr", {bus16.reg_we_o, bus16.reg_waddr_o}, 6'b1_00001);
    chk("pt_valid", bus16.valid_o, 1'b1);

    // hold for three cycles while decode keeps changing
    in_s.inst = 32'h00A0_0113;
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_s = rand_st();
      tick();
      chk("hold_inst", bus16.inst_o, 32'h00A0_0113);
      chk("hold_valid", bus16.valid_o, 1'b1);
    end
    hold = 1'b0;
    nxt = 32'h0030_0193;
    in_s.inst = nxt;
    tick();
    chk("release_inst", bus16.inst_o, 32'h0030_0193);

    // taken jump during a stall squashes the stage
    in_s.we = 1'b1; in_s.cwe = 1'b1;
    tick();
    hold = 1'b1; jump = 1'b1;
    tick();
    chk("jf_inst", bus16.inst_o, 32'h0000_0013);
    chk("jf_we", {bus16.reg_we_o, bus16.csr_we_o}, 2'b00);
    chk("jf_valid", bus16.valid_o, 1'b0);
    chk("jf_cnt", bus16.bubble_cnt_o, 16'd1);
    hold = 1'b0; jump = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_s  = rand_st();
      rst   = ($urandom_range(0, 99) >= 3);
      flush = ($urandom_range(0, 99) < 10);
      jump  = ($urandom_range(0, 99) < 10);
      hold  = ($urandom_range(0, 99) < 30);
      tick();
    end

    // counter saturation on the narrow build
    rst = 1'b0; flush = 1'b0; jump = 1'b0; hold = 1'b0;
    tick();
    rst = 1'b1; flush = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      hold = 1'($urandom_range(0, 1));
      tick();
      chk("sat4", bus4.bubble_cnt_o, (i < 15) ? i : 15);
      chk("sat16", bus16.bubble_cnt_o, i);
      if (i == 15) chk("sat4_at15", bus4.bubble_cnt_o, 4'hF);
    end

    // reset arriving during a stall clears everything, counter included
    flush = 1'b0; hold = 1'b0;
    in_s = rand_st(); in_s.we = 1'b1;
    tick();
    hold = 1'b1;
    tick();
    chk("stall_valid", bus16.valid_o, 1'b1);
    rst = 1'b0;
    tick();
    chk("rms_inst", bus16.inst_o, 32'h0000_0013);
    chk("rms_op2", bus16.op2_o, 32'h0);
    chk("rms_we", bus16.reg_we_o, 1'b0);
    chk("rms_valid", bus16.valid_o, 1'b0);
    chk("rms_cnt16", bus16.bubble_cnt_o, 16'h0);
    chk("rms_cnt4", bus4.bubble_cnt_o, 4'h0);
    rst = 1'b1; hold = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline register between the decode stage and the execute stage of the RV32I core.
- Captures every decode-stage output on each clock and presents it to ex one cycle later.
- Supports stall (hold), flush on a taken jump/branch from ex, and bubble (NOP) insertion.
- Keeps a valid bit and a saturating bubble counter for debug and performance visibility.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word presented to ex while a bubble is in the stage (addi x0,x0,0).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- hold_i  in  1  stall from ctrl; the stage keeps its contents.
- flush_i  in  1  flush request from ctrl (e.g. trap); the stage loads a bubble.
- ex_jump_flag_i  in  1  taken jump/branch resolved in ex; the stage loads a bubble.
- inst_i, inst_addr_i  in  32 each  instruction word and its PC from decode.
- op1_i, op2_i, op1_jump_i, op2_jump_i  in  32 each  ALU and jump-target operands.
- reg1_rdata_i, reg2_rdata_i  in  32 each  register-file read data.
- reg_we_i  in  1;  reg_waddr_i  in  5  register write-back request.
- csr_we_i  in  1;  csr_rdata_i  in  32;  csr_waddr_i  in  32  CSR write-back request and read data.
- Outputs with the same names and the _o suffix, with matching widths.
- valid_o  out  1  the stage holds a real instruction.
- bubble_cnt_o  out  CNT_W  count of bubbles inserted; saturates at all-ones.

Behaviour:
- Reset (rst==0 at a clock edge):
  - inst_o = NOP_INST.
  - All data and address outputs = 0.
  - reg_we_o = 0, csr_we_o = 0, valid_o = 0, bubble_cnt_o = 0.
- Priority at each edge when rst==1: flush > hold > load.
- Flush (flush_i | ex_jump_flag_i):
  - Load the reset values for every field except bubble_cnt_o.
  - valid_o = 0.
  - bubble_cnt_o increments by 1 unless it is saturated.
  - A flush wins over a simultaneous hold, so the wrong-path instruction is always removed.
- Hold (hold_i and no flush):
  - Every register, including valid_o, keeps its value.
  - bubble_cnt_o does not change.
- Load (neither flush nor hold):
  - Every _o register takes its _i value.
  - valid_o = 1.
- Latency: exactly one cycle from an input to the matching output. There is no combinational path from input to output.
- Write enables (reg_we_o, csr_we_o) are forced to 0 whenever valid_o==0, so a bubble can never write back.
- Sustained hold: contents stay stable for any number of cycles. The first edge after hold drops loads the current inputs.
- Reset arriving during a hold or flush: reset wins and applies all reset values.
- Counter arithmetic: CNT_W-bit unsigned. At all-ones a further flush leaves it at all-ones, with no wrap.
- No FSM. Each field is an independent register with shared load, hold and flush control.

Decomposition:
- Shared defines (existing bus and RV32I headers): InstBus, InstAddrBus, RegBus, RegAddrBus and MemAddrBus widths; ZeroWord, ZeroReg, WriteEnable/WriteDisable; add an INST_NOP constant equal to NOP_INST.
- Sub-module pipe_dff:
  - Parameters: width DW and reset/flush value.
  - Inputs: clk, rst, hold, flush, d.
  - Output: q.
  - Implements the priority reset > flush > hold > load.
  - id_ex instantiates one pipe_dff per field.
- The bubble counter and valid bit are local logic in id_ex.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> inst_o=32'h0000_0013, all other outputs 0, valid_o=0, bubble_cnt_o=0.
- Pass-through: rst=1, inst_i=32'h0050_0093, op2_i=5, reg_we_i=1, reg_waddr_i=1 -> one edge later the same values appear at the outputs and valid_o=1; no change is visible before that edge.
- Hold: load inst 0x00A0_0113, then hold_i=1 for 3 cycles while inst_i changes -> inst_o stays 0x00A0_0113 for all 3 cycles; the first edge after release loads the new inst_i.
- Jump flush during hold: valid stage, hold_i=1 and ex_jump_flag_i=1 on the same edge -> inst_o=NOP, reg_we_o=0, csr_we_o=0, valid_o=0, bubble_cnt_o increments from 0 to 1.
- Counter saturation: CNT_W=4 build with 17 consecutive flush_i edges -> bubble_cnt_o=4'hF after the 15th edge and stays 4'hF.
- Reset mid-stall: hold_i=1 with a valid instruction, then rst=0 for one edge -> all reset values, including bubble_cnt_o=0.
